// File: rtl/axi_read_arbiter_2to1_if.sv
// axi_read_arbiter_2to1_if: one AXI4 read channel (AR + R); master drives AR, slave drives R.
interface axi_read_arbiter_2to1_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic                  arlock;
    logic                  arid;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;
    logic                  rid;
    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arcache, arlock, arid, rready,
        input  arready, rvalid, rdata, rlast, rresp, rid
    );
    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arcache, arlock, arid, rready,
        output arready, rvalid, rdata, rlast, rresp, rid
    );
endinterface

// File: rtl/axi_read_arbiter_2to1.sv
// axi_read_arbiter_2to1: round-robin share of one AXI4 read channel between I-cache (s0) and D-cache (s1).
// One burst in flight; grant held from AR issue until the last R beat.
module axi_read_arbiter_2to1 (
    input logic clk,
    input logic rst,
    axi_read_arbiter_2to1_if.slave  s0,
    axi_read_arbiter_2to1_if.slave  s1,
    axi_read_arbiter_2to1_if.master m
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;
    logic   grant, grant_nxt, last_grant;
    logic   in_addr, in_data, any_req;
    assign in_addr = state == ADDR;
    assign in_data = state == DATA;
    assign any_req = s0.arvalid | s1.arvalid;
    always_comb begin
        m.arvalid  = in_addr & (grant ? s1.arvalid : s0.arvalid);
        m.araddr   = grant ? s1.araddr : s0.araddr;
        m.arlen    = grant ? s1.arlen : s0.arlen;
        m.arsize   = grant ? s1.arsize : s0.arsize;
        m.arburst  = grant ? s1.arburst : s0.arburst;
        m.arcache  = grant ? s1.arcache : s0.arcache;
        m.arlock   = grant ? s1.arlock : s0.arlock;
        m.arid     = grant;
        s0.arready = in_addr & ~grant & m.arready;
        s1.arready = in_addr & grant & m.arready;
        m.rready   = in_data & (grant ? s1.rready : s0.rready);
        s0.rvalid  = in_data & ~grant & m.rvalid;
        s1.rvalid  = in_data & grant & m.rvalid;
        s0.rdata   = m.rdata;
        s1.rdata   = m.rdata;
        s0.rlast   = m.rlast;
        s1.rlast   = m.rlast;
        s0.rresp   = m.rresp;
        s1.rresp   = m.rresp;
        s0.rid     = m.rid;
        s1.rid     = m.rid;
    end
    // A dropped arvalid in ADDR simply stalls; the grant is never re-arbitrated mid-burst.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: if (any_req) begin
                state_nxt = ADDR;
                grant_nxt = (s0.arvalid & s1.arvalid) ? ~last_grant : s1.arvalid;
            end
            ADDR: if (in_addr & (grant ? s1.arvalid : s0.arvalid) & m.arready) state_nxt = DATA;
            DATA: if (m.rvalid & (grant ? s1.rready : s0.rready) & m.rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= (state == IDLE && any_req) ? grant_nxt : last_grant;
        end
    end
endmodule

// File: doc/axi_read_arbiter_2to1.md
Name: axi_read_arbiter_2to1

Overview:
Shares the single external AXI4 read channel between the L1 instruction cache (port 0) and the L1 data cache (port 1). It arbitrates AR requests round-robin and tags the winner with ARID. The grant is held until the last R beat of that burst, and R beats are routed back to the granted port. It sits between the two cache refill engines and the memory-side AXI interconnect, with one burst outstanding at a time.

Parameters:
DATA_WIDTH, 128, R data width; matches the cache fetch-group width.
ADDR_WIDTH, 32, AR address width.

Ports:
clk  input  1  clock.
rst  input  1  reset: asynchronous, active-low (asserted when 0).
sN_axi_arvalid (N=0,1)  input  1  request valid from port N.
sN_axi_arready  output  1  request accepted on port N.
sN_axi_araddr  input  ADDR_WIDTH  burst start address.
sN_axi_arlen  input  8  burst length minus 1.
sN_axi_arsize  input  3  beat size.
sN_axi_arburst  input  2  burst type.
sN_axi_arcache  input  4  cache attributes.
sN_axi_arlock  input  1  lock attribute.
sN_axi_rvalid  output  1  beat valid to port N.
sN_axi_rready  input  1  port N ready for a beat.
sN_axi_rdata  output  DATA_WIDTH  beat data.
sN_axi_rlast  output  1  last beat.
sN_axi_rresp  output  2  beat response.
m_axi_arvalid  output  1  request valid to memory.
m_axi_arready  input  1  memory accepted the request.
m_axi_araddr / arlen / arsize / arburst / arcache / arlock  output  ADDR_WIDTH/8/3/2/4/1  forwarded from the granted port.
m_axi_arid  output  1  index of the granted port.
m_axi_rvalid  input  1  beat valid from memory.
m_axi_rready  output  1  ready to memory.
m_axi_rdata  input  DATA_WIDTH  beat data.
m_axi_rlast  input  1  last beat.
m_axi_rid  input  1  beat ID.
m_axi_rresp  input  2  beat response.

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, grant (1 bit), last_grant (1 bit).
- Reset (rst=0, asynchronous): state=IDLE, grant=0, last_grant=1, so port 0 wins the first tie. All valid/ready outputs are 0 while in IDLE.
- IDLE, request present (s0_arvalid | s1_arvalid):
  - A single requester is granted.
  - If both request, grant = !last_grant.
  - Next state ADDR; grant and last_grant are updated on that same edge.
- IDLE, no request: stay in IDLE.
- ADDR:
  - m_axi_ar* = granted port's fields; m_axi_arvalid = sgrant_arvalid; m_axi_arid = grant.
  - sgrant_arready = m_axi_arready. The other port's arready = 0.
  - On m_axi_arvalid & m_axi_arready, go to DATA.
  - If the granted port drops arvalid (protocol violation), stay in ADDR; no re-arbitration.
- DATA:
  - sgrant_rvalid = m_axi_rvalid; m_axi_rready = sgrant_rready; rdata/rlast/rresp pass through.
  - The other port's rvalid = 0. Its rdata/rlast/rresp outputs may carry m_axi values.
  - On m_axi_rvalid & m_axi_rready & m_axi_rlast, go to IDLE.
  - m_axi_rid is not used for routing; only one burst is ever outstanding.
- Latency: AR appears on m_axi one cycle after the request is seen in IDLE. The R path is combinational, with zero added latency. The minimum gap between the last R beat and the next AR is 1 cycle (the IDLE cycle).
- In IDLE and ADDR, m_axi_rready = 0. In IDLE and DATA, m_axi_arvalid = 0 and both sN_arready = 0.
- Fairness: port 0 and port 1 alternate while both request continuously. A lone requester is served back-to-back.
- Error responses (rresp != 0) are forwarded unmodified. A burst always completes through rlast.
- No flush input. The caches finish any burst they have started, so an issued burst is always drained.
- Reset asserted mid-burst returns the block to IDLE immediately. The external memory must also be reset, because the block gives no drain guarantee.

Test Plan:
- Single port 0 request: araddr=0x0000_1000, arlen=7 -> m_axi_arvalid=1 with arid=0 one cycle after the request. Eight beats are routed only to s0, s0_rlast on beat 8. s1_rvalid=0 throughout.
- Simultaneous requests from reset: s0 araddr=0x100, s1 araddr=0x200 -> port 0 is served first (arid=0). Port 1 is served next (arid=1, araddr=0x200) after port 0's rlast plus 1 idle cycle.
- Continuous requests on both ports for 4 bursts -> grant order is 0,1,0,1.
- Backpressure: m_axi_arready held low for 5 cycles -> m_axi_arvalid and araddr stay stable; the non-granted port's arready stays 0. Then s1_rready toggling 1,0,1 -> m_axi_rready mirrors it and no beat is lost or duplicated.
- Error response: rresp=2'b10 on the last beat -> s1_rresp=2'b10 with rlast=1, and the state returns to IDLE.
- Asynchronous reset pulse mid-DATA (beat 3 of 8) -> m_axi_rready and all sN_rvalid drop to 0 immediately, without waiting for a clock edge. After release, the block is in IDLE and the first tie grants port 0.
